// File: rtl/priority_decoder_2to4_seq.sv
// Decodes accepted {Y1,Y0,V} codes into a timed one-hot pulse on D.
// Ports: clk, rst (sync, active-high); Y1/Y0/V code in; ready, busy,
// drop status; D[3:0] pulse; cnt0..cnt3 saturating per-channel counts.
// Optional macro PRIORITY_DECODER_GAP_EN adds a one-cycle GAP state
// after each pulse.
module priority_decoder_2to4_seq #(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y1,
  input  logic             Y0,
  input  logic             V,
  output logic             ready,
  output logic [3:0]       D,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

`ifdef PRIORITY_DECODER_GAP_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  localparam logic [7:0]       TLOAD = 8'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_timer;
  logic [3:0]       r_d;
  logic             r_drop;
  logic [CNT_W-1:0] r_cnt [4];
  logic [1:0]       w_code;

  assign w_code = {Y1, Y0};
  assign ready  = (r_state == IDLE);
  assign busy   = (r_state != IDLE);
  assign D      = r_d;
  assign drop   = r_drop;
  assign cnt0   = r_cnt[0];
  assign cnt1   = r_cnt[1];
  assign cnt2   = r_cnt[2];
  assign cnt3   = r_cnt[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_d     <= '0;
      r_drop  <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      // A code offered while not ready is flagged and discarded.
      r_drop <= V && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (V) begin
            r_d     <= 4'b0001 << w_code;
            r_timer <= TLOAD;
            r_state <= HOLD;
            if (r_cnt[w_code] != '1)
              r_cnt[w_code] <= r_cnt[w_code] + ONE;
          end
        end
        HOLD: begin
          if (r_timer == 8'd0) begin
            r_d     <= '0;
`ifdef PRIORITY_DECODER_GAP_EN
            r_state <= GAP;
`else
            r_state <= IDLE;
`endif
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
`ifdef PRIORITY_DECODER_GAP_EN
        GAP: r_state <= IDLE;
`endif
        default: begin
          r_state <= IDLE;
          r_d     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_decoder_2to4_seq.sv
// Bench for priority_decoder_2to4_seq: two instances (4-cycle/8-bit and
// 1-cycle/2-bit) driven in lockstep and checked against a countdown model.
module tb_priority_decoder_2to4_seq;

`ifdef PRIORITY_DECODER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst, Y1, Y0, V;
  logic       rdyA, busyA, dropA, rdyB, busyB, dropB;
  logic [3:0] dA, dB;
  logic [7:0] a0, a1, a2, a3;
  logic [1:0] b0, b1, b2, b3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  priority_decoder_2to4_seq #(.PULSE_LEN(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .Y1(Y1), .Y0(Y0), .V(V),
    .ready(rdyA), .D(dA), .busy(busyA), .drop(dropA),
    .cnt0(a0), .cnt1(a1), .cnt2(a2), .cnt3(a3)
  );

  priority_decoder_2to4_seq #(.PULSE_LEN(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .Y1(Y1), .Y0(Y0), .V(V),
    .ready(rdyB), .D(dB), .busy(busyB), .drop(dropB),
    .cnt0(b0), .cnt1(b1), .cnt2(b2), .cnt3(b3)
  );

  // Model: cycles until ready again, cycles of pulse left, counts.
  int plen [2] = '{4, 1};
  int cmax [2] = '{255, 3};
  int m_rem [2];
  int m_pl [2];
  int m_code [2];
  int m_drop [2];
  int m_cnt [2][4];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step(int i, bit r, bit v, int c);
    if (r) begin
      m_rem[i] = 0; m_pl[i] = 0; m_drop[i] = 0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
    end else begin
      m_drop[i] = (v && m_rem[i] != 0) ? 1 : 0;
      if (v && m_rem[i] == 0) begin
        m_pl[i]   = plen[i];
        m_rem[i]  = plen[i] + GAP;
        m_code[i] = c;
        if (m_cnt[i][c] < cmax[i]) m_cnt[i][c]++;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_pl[i] > 0) m_pl[i]--;
      end
    end
  endtask

  function automatic int exp_d(int i);
    return (m_pl[i] > 0) ? (1 << m_code[i]) : 0;
  endfunction

  task automatic check_all();
    chk("A.D", int'(dA), exp_d(0));
    chk("A.ready", int'(rdyA), int'(m_rem[0] == 0));
    chk("A.busy", int'(busyA), int'(m_rem[0] != 0));
    chk("A.drop", int'(dropA), m_drop[0]);
    chk("A.cnt0", int'(a0), m_cnt[0][0]);
    chk("A.cnt1", int'(a1), m_cnt[0][1]);
    chk("A.cnt2", int'(a2), m_cnt[0][2]);
    chk("A.cnt3", int'(a3), m_cnt[0][3]);
    chk("B.D", int'(dB), exp_d(1));
    chk("B.ready", int'(rdyB), int'(m_rem[1] == 0));
    chk("B.busy", int'(busyB), int'(m_rem[1] != 0));
    chk("B.drop", int'(dropB), m_drop[1]);
    chk("B.cnt0", int'(b0), m_cnt[1][0]);
    chk("B.cnt1", int'(b1), m_cnt[1][1]);
    chk("B.cnt2", int'(b2), m_cnt[1][2]);
    chk("B.cnt3", int'(b3), m_cnt[1][3]);
  endtask

  task automatic cycle(bit r, bit v, int c);
    rst = r; V = v; {Y1, Y0} = 2'(c);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, r, v, c);
    #1;
    check_all();
  endtask

  typedef struct {
    bit       r;
    bit       v;
    int       c;
    bit [3:0] d;
    bit       rdy;
    bit       drp;
    int       c1;
    int       c3;
  } vec_t;

  vec_t tbl [8];
  int   sat_exp [5] = '{1, 2, 3, 3, 3};
  int   nbusy, nhigh, tmo;

  initial begin
    rst = 1'b1; V = 1'b0; Y1 = 1'b0; Y0 = 1'b0;
    for (int i = 0; i < 2; i++) model_step(i, 1'b1, 1'b0, 0);

    // Reset, accept code 3, offer code 1 three times while held.
    tbl[0] = '{1'b1, 1'b0, 0, 4'b0000, 1'b1, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 0, 4'b0000, 1'b1, 1'b0, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 3, 4'b1000, 1'b0, 1'b0, 0, 1};
    tbl[3] = '{1'b0, 1'b1, 1, 4'b1000, 1'b0, 1'b1, 0, 1};
    tbl[4] = '{1'b0, 1'b1, 1, 4'b1000, 1'b0, 1'b1, 0, 1};
    tbl[5] = '{1'b0, 1'b1, 1, 4'b1000, 1'b0, 1'b1, 0, 1};
    tbl[6] = '{1'b0, 1'b0, 0, 4'b0000, 1'(GAP == 0), 1'b0, 0, 1};
    tbl[7] = '{1'b0, 1'b0, 0, 4'b0000, 1'b1, 1'b0, 0, 1};
    for (int n = 0; n < 8; n++) begin
      cycle(tbl[n].r, tbl[n].v, tbl[n].c);
      chk($sformatf("tbl%0d.D", n), int'(dA), int'(tbl[n].d));
      chk($sformatf("tbl%0d.ready", n), int'(rdyA), int'(tbl[n].rdy));
      chk($sformatf("tbl%0d.drop", n), int'(dropA), int'(tbl[n].drp));
      chk($sformatf("tbl%0d.cnt1", n), int'(a1), tbl[n].c1);
      chk($sformatf("tbl%0d.cnt3", n), int'(a3), tbl[n].c3);
    end

    // Single code 2: pulse width and busy length.
    cycle(1, 0, 0); cycle(1, 0, 0);
    cycle(0, 1, 2);
    nbusy = 0; nhigh = 0;
    if (busyA) nbusy++;
    if (dA == 4'b0100) nhigh++;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0);
      if (busyA) nbusy++;
      if (dA == 4'b0100) nhigh++;
    end
    chk("single.busy_len", nbusy, 4 + GAP);
    chk("single.pulse_len", nhigh, 4);
    chk("single.cnt2", int'(a2), 1);

    // All codes in turn.
    for (int c = 0; c < 4; c++) begin
      tmo = 0;
      while (!rdyA && tmo < 20) begin cycle(0, 0, 0); tmo++; end
      chk("seq.ready_wait", int'(tmo < 20), 1);
      cycle(0, 1, c);
      chk("seq.D", int'(dA), 1 << c);
    end

    // Reset in the second HOLD cycle.
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("rstmid.D", int'(dA), 0);
    chk("rstmid.cnt1", int'(a1), 0);
    cycle(0, 0, 0);
    chk("rstmid.ready", int'(rdyA), 1);
    chk("rstmid.D_after", int'(dA), 0);

    // Saturation on the 2-bit instance.
    cycle(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tmo = 0;
      while (!rdyB && tmo < 20) begin cycle(0, 0, 0); tmo++; end
      chk("sat.ready_wait", int'(tmo < 20), 1);
      cycle(0, 1, 0);
      chk($sformatf("sat.cnt0_%0d", k), int'(b0), sat_exp[k]);
    end

    // Continuous V with code 2.
    cycle(1, 0, 0);
    nhigh = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 1, 2);
      if (dB == 4'b0100) nhigh++;
    end
    chk("cont.B_pulses", nhigh, 12 / (2 + GAP));

    // Random traffic with occasional reset.
    for (int k = 0; k < 3000; k++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
